// File: rtl/intercon_wb_pkg.sv
// Shared state encoding and decode helpers for the registered Wishbone interconnect.
package intercon_wb_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  function automatic int sel_width(input int data_width);
    return data_width / 8;
  endfunction

  // present is the slave-present mask zero-extended to 256 bits
  function automatic logic is_mapped(input int unsigned idx, input int unsigned num_slaves,
                                     input logic [255:0] present);
    if (idx >= num_slaves || idx > 255) return 1'b0;
    return present[idx[7:0]];
  endfunction

endpackage

// File: rtl/intercon_wb_timer.sv
// Slave response watchdog: counts BUSY cycles, expires on the last allowed cycle.
// Zero latency on expire; TIMEOUT_CYCLES = 0 disables expiry entirely.
module intercon_wb_timer #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_BITS   = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr,
  input  logic en,
  output logic expire
);

  logic [TIMEOUT_BITS-1:0] count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + TIMEOUT_BITS'(1);
    end
  end

  assign expire = (TIMEOUT_CYCLES != 0) && en &&
                  (count == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/intercon_wb_reg.sv
// Registered 1-to-N classic Wishbone interconnect with present mask, bus error, timeout and abort.
// Slave strobe one edge after the request is sampled; master ack/err one edge after slave response.
module intercon_wb_reg
  import intercon_wb_pkg::*;
#(
  parameter int WB_DATA_WIDTH      = 32,
  parameter int WB_ADDR_WIDTH      = 32,
  parameter int WB_NUM_SLAVES      = 8,
  parameter int WB_NUM_SLAVES_BITS = 3,
  parameter int SLAVE_ADDRESS_BITS = 20,
  parameter logic [WB_NUM_SLAVES-1:0] SLAVE_PRESENT = '1,
  parameter int TIMEOUT_CYCLES     = 255,
  parameter int TIMEOUT_BITS       = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [WB_DATA_WIDTH-1:0]               master_dat_i,
  input  logic                                   master_we_i,
  input  logic [sel_width(WB_DATA_WIDTH)-1:0]    master_sel_i,
  input  logic [WB_ADDR_WIDTH-1:0]               master_adr_i,
  input  logic                                   master_cyc_i,
  input  logic                                   master_stb_i,
  output logic [WB_DATA_WIDTH-1:0]               master_dat_o,
  output logic                                   master_ack_o,
  output logic                                   master_err_o,
  output logic [WB_DATA_WIDTH-1:0]               slave_dat_o,
  output logic [WB_NUM_SLAVES-1:0]               slave_we_o,
  output logic [sel_width(WB_DATA_WIDTH)-1:0]    slave_sel_o,
  output logic [WB_ADDR_WIDTH-1:0]               slave_adr_o,
  output logic [WB_NUM_SLAVES-1:0]               slave_cyc_o,
  output logic [WB_NUM_SLAVES-1:0]               slave_stb_o,
  input  logic [WB_DATA_WIDTH*WB_NUM_SLAVES-1:0] slave_dat_i,
  input  logic [WB_NUM_SLAVES-1:0]               slave_ack_i,
  input  logic [WB_NUM_SLAVES-1:0]               slave_err_i
);

  localparam int unsigned NS = WB_NUM_SLAVES;

  logic [1:0]                    state;
  logic [WB_NUM_SLAVES_BITS-1:0] idx;
  logic [WB_NUM_SLAVES_BITS-1:0] idx_q;
  logic                          mapped;
  logic [WB_NUM_SLAVES-1:0]      onehot;
  logic                          sel_ack;
  logic                          sel_err;
  logic [WB_DATA_WIDTH-1:0]      sel_dat;
  logic                          expire;

  assign idx    = master_adr_i[SLAVE_ADDRESS_BITS +: WB_NUM_SLAVES_BITS];
  assign mapped = is_mapped(32'(idx), NS, 256'(SLAVE_PRESENT));
  assign onehot = WB_NUM_SLAVES'(1) << idx;

  // Only the latched slave may complete the transfer; others are ignored.
  always_comb begin
    sel_ack = 1'b0;
    sel_err = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < WB_NUM_SLAVES; i++) begin
      if (idx_q == WB_NUM_SLAVES_BITS'(i)) begin
        sel_ack = slave_ack_i[i];
        sel_err = slave_err_i[i];
        sel_dat = slave_dat_i[i*WB_DATA_WIDTH +: WB_DATA_WIDTH];
      end
    end
  end

  intercon_wb_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .TIMEOUT_BITS  (TIMEOUT_BITS)
  ) u_timer (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .clr   (state != BUSY),
    .en    (state == BUSY),
    .expire(expire)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= IDLE;
      idx_q        <= '0;
      master_dat_o <= '0;
      master_ack_o <= 1'b0;
      master_err_o <= 1'b0;
      slave_dat_o  <= '0;
      slave_we_o   <= '0;
      slave_sel_o  <= '0;
      slave_adr_o  <= '0;
      slave_cyc_o  <= '0;
      slave_stb_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          master_ack_o <= 1'b0;
          master_err_o <= 1'b0;
          if (master_cyc_i && master_stb_i) begin
            slave_adr_o <= master_adr_i;
            slave_dat_o <= master_dat_i;
            slave_sel_o <= master_sel_i;
            idx_q       <= idx;
            if (mapped) begin
              state       <= BUSY;
              slave_cyc_o <= onehot;
              slave_stb_o <= onehot;
              slave_we_o  <= master_we_i ? onehot : '0;
            end else begin
              state        <= RESP;
              master_err_o <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (!master_cyc_i) begin
            state       <= IDLE;
            slave_cyc_o <= '0;
            slave_stb_o <= '0;
            slave_we_o  <= '0;
          end else if (sel_err || sel_ack || expire) begin
            // Error beats ack when both arrive together; data only captured on a clean ack.
            state       <= RESP;
            slave_cyc_o <= '0;
            slave_stb_o <= '0;
            slave_we_o  <= '0;
            if (sel_ack && !sel_err) begin
              master_ack_o <= 1'b1;
              master_dat_o <= sel_dat;
            end else begin
              master_err_o <= 1'b1;
            end
          end
        end
        RESP: begin
          state        <= IDLE;
          master_ack_o <= 1'b0;
          master_err_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
